// File: rtl/dsp_pkg.sv
// dsp_pkg: shared fixed-point helpers and types for the DSP core
package dsp_pkg;

    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    // Half-LSB offset added before an arithmetic right shift by frac bits (round half-up)
    function automatic int rnd_const(input int frac);
        return 1 << (frac - 1);
    endfunction

    // Clamp x into the signed range of a w-bit word; hit reports that clamping happened
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] x, input int w, output logic hit);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        hit = (x > hi) || (x < lo);
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

endpackage

// File: rtl/cplx_mult_pipe.sv
// cplx_mult_pipe: two-stage pipelined complex multiply b * W (or conj W) with rounding back to data scale
module cplx_mult_pipe
    import dsp_pkg::*;
#(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic signed [DW-1:0] i_br,
    input  logic signed [DW-1:0] i_bi,
    input  logic signed [TW-1:0] i_wr,
    input  logic signed [TW-1:0] i_wi,
    input  logic                 i_inverse,
    output logic                 o_valid,
    output logic signed [DW+2:0] o_pr,
    output logic signed [DW+2:0] o_pi
);

    localparam int PW = DW + TW + 1;
    localparam int QW = DW + TW + 2;
    localparam int OW = DW + 3;
    localparam logic signed [QW-1:0] RND = QW'(rnd_const(TW - 1));

    logic signed [TW:0]   w_wi_x;
    logic signed [TW:0]   w_wi_eff;
    logic signed [QW-1:0] w_pr;
    logic signed [QW-1:0] w_pi;
    logic signed [QW-1:0] w_pr_s;
    logic signed [QW-1:0] w_pi_s;
    logic signed [PW-1:0] r_rr;
    logic signed [PW-1:0] r_ii;
    logic signed [PW-1:0] r_ri;
    logic signed [PW-1:0] r_ir;
    logic signed [OW-1:0] r_pr;
    logic signed [OW-1:0] r_pi;
    logic                 r_v1;
    logic                 r_v2;

    // One extra bit so negating the most negative twiddle stays exact
    assign w_wi_x   = {i_wi[TW-1], i_wi};
    assign w_wi_eff = i_inverse ? -w_wi_x : w_wi_x;

    assign w_pr   = QW'(r_rr) - QW'(r_ii);
    assign w_pi   = QW'(r_ri) + QW'(r_ir);
    assign w_pr_s = (w_pr + RND) >>> (TW - 1);
    assign w_pi_s = (w_pi + RND) >>> (TW - 1);

    // S1: register the four raw partial products
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_rr <= '0;
            r_ii <= '0;
            r_ri <= '0;
            r_ir <= '0;
        end else if (i_en) begin
            r_v1 <= i_valid;
            r_rr <= PW'(i_br) * PW'(i_wr);
            r_ii <= PW'(i_bi) * PW'(w_wi_eff);
            r_ri <= PW'(i_br) * PW'(w_wi_eff);
            r_ir <= PW'(i_bi) * PW'(i_wr);
        end
    end

    // S2: combine, round half-up and drop the twiddle fraction bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_pr <= '0;
            r_pi <= '0;
        end else if (i_en) begin
            r_v2 <= r_v1;
            r_pr <= OW'(w_pr_s);
            r_pi <= OW'(w_pi_s);
        end
    end

    assign o_valid = r_v2;
    assign o_pr    = r_pr;
    assign o_pi    = r_pi;

endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: 3-stage radix-2 DIT butterfly with conj twiddle, 1/2 scaling, saturation and flow control
module butterfly_pipe
    import dsp_pkg::*;
#(
    parameter int DW   = 16,
    parameter int TW   = 16,
    parameter int TAGW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] ar,
    input  logic signed [DW-1:0] ai,
    input  logic signed [DW-1:0] br,
    input  logic signed [DW-1:0] bi,
    input  logic signed [TW-1:0] wr,
    input  logic signed [TW-1:0] wi,
    input  logic                 inverse,
    input  logic                 scale,
    input  logic [TAGW-1:0]      tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out0r,
    output logic signed [DW-1:0] out0i,
    output logic signed [DW-1:0] out1r,
    output logic signed [DW-1:0] out1i,
    output logic [TAGW-1:0]      tag_out,
    output logic                 sat,
    output logic                 ovf_sticky,
    input  logic                 clear,
    output logic [15:0]          sat_cnt
);

    localparam int OW = DW + 3;
    localparam int SW = DW + 4;

    logic                 w_en;
    logic                 w_v2;
    logic signed [OW-1:0] w_pr;
    logic signed [OW-1:0] w_pi;
    logic signed [SW-1:0] w_s [4];
    logic signed [SW-1:0] w_h [4];
    logic signed [DW-1:0] w_c [4];
    logic [3:0]           w_hit;

    logic signed [DW-1:0] r_ar1;
    logic signed [DW-1:0] r_ai1;
    logic signed [DW-1:0] r_ar2;
    logic signed [DW-1:0] r_ai2;
    logic                 r_sc1;
    logic                 r_sc2;
    logic [TAGW-1:0]      r_tag1;
    logic [TAGW-1:0]      r_tag2;
    logic [TAGW-1:0]      r_tag3;
    logic signed [DW-1:0] r_o [4];
    logic                 r_v3;
    logic                 r_sat;
    logic                 r_ovf;
    logic [15:0]          r_cnt;

    // Whole pipe advances together; only a held output blocks it
    assign w_en     = !r_v3 || out_ready;
    assign in_ready = w_en;

    cplx_mult_pipe #(
        .DW (DW),
        .TW (TW)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_en),
        .i_valid   (in_valid),
        .i_br      (br),
        .i_bi      (bi),
        .i_wr      (wr),
        .i_wi      (wi),
        .i_inverse (inverse),
        .o_valid   (w_v2),
        .o_pr      (w_pr),
        .o_pi      (w_pi)
    );

    // Carry operand a, scale and tag alongside the multiplier stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar1  <= '0;
            r_ai1  <= '0;
            r_sc1  <= 1'b0;
            r_tag1 <= '0;
            r_ar2  <= '0;
            r_ai2  <= '0;
            r_sc2  <= 1'b0;
            r_tag2 <= '0;
        end else if (w_en) begin
            r_ar1  <= ar;
            r_ai1  <= ai;
            r_sc1  <= scale;
            r_tag1 <= tag_in;
            r_ar2  <= r_ar1;
            r_ai2  <= r_ai1;
            r_sc2  <= r_sc1;
            r_tag2 <= r_tag1;
        end
    end

    // S3 datapath: full-width sums, optional rounded halving, clamp to DW bits
    always_comb begin
        w_hit   = '0;
        w_s[0]  = SW'(r_ar2) + SW'(w_pr);
        w_s[1]  = SW'(r_ai2) + SW'(w_pi);
        w_s[2]  = SW'(r_ar2) - SW'(w_pr);
        w_s[3]  = SW'(r_ai2) - SW'(w_pi);
        for (int k = 0; k < 4; k++) begin
            w_h[k] = r_sc2 ? ((w_s[k] + SW'(1)) >>> 1) : w_s[k];
            w_c[k] = DW'(sat_clip(64'(w_h[k]), DW, w_hit[k]));
        end
    end

    // S3 register: results stay put while the downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_tag3 <= '0;
            r_sat  <= 1'b0;
            for (int k = 0; k < 4; k++) r_o[k] <= '0;
        end else if (w_en) begin
            r_v3   <= w_v2;
            r_tag3 <= r_tag2;
            r_sat  <= w_v2 && (|w_hit);
            for (int k = 0; k < 4; k++) r_o[k] <= w_c[k];
        end
    end

    // Overflow bookkeeping on accepted outputs; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (r_v3 && out_ready && r_sat) begin
            r_ovf <= 1'b1;
            r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        end
    end

    assign out_valid  = r_v3;
    assign out0r      = r_o[0];
    assign out0i      = r_o[1];
    assign out1r      = r_o[2];
    assign out1i      = r_o[3];
    assign tag_out    = r_tag3;
    assign sat        = r_sat;
    assign ovf_sticky = r_ovf;
    assign sat_cnt    = r_cnt;

endmodule
